// File: rtl/crc_check_pkg.sv
// Shared constants and elaboration-time helpers for the CRC check datapath.
package crc_check_pkg;

    // Bits needed to hold the values 0 .. value-1.
    function automatic int get_width(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/crc_check_bit_step.sv
// One MSB-first bit of the CRC shift-XOR recurrence; purely combinational.
module crc_bit_step #(
    parameter int VERI_BITS = 32
) (
    input  logic [VERI_BITS-1:0] crc_cur,
    input  logic                 bit_in,
    input  logic [VERI_BITS-1:0] poly,
    output logic [VERI_BITS-1:0] crc_nxt
);

    always_comb begin
        crc_nxt = {crc_cur[VERI_BITS-2:0], 1'b0} ^ ((crc_cur[VERI_BITS-1] ^ bit_in) ? poly : '0);
    end

endmodule

// File: rtl/crc_check.sv
// Receive-side CRC verifier: shifts {data, crc_in} MSB-first through the
// generator recurrence and reports pass when the final residue is zero.
module crc_check
    import crc_check_pkg::*;
#(
    parameter int VERI_BITS = 32,
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [VERI_BITS-1:0] veri_poly,
    input  logic [DATA_BITS-1:0] data,
    input  logic [VERI_BITS-1:0] crc_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [VERI_BITS-1:0] residue
);

    localparam int TOTAL_BITS = DATA_BITS + VERI_BITS;
    // One extra count so the terminal value TOTAL_BITS fits without wrapping.
    localparam int CNT_W = get_width(TOTAL_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL_BITS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [TOTAL_BITS-1:0]   shift_q, shift_d;
    logic [VERI_BITS-1:0]    poly_q, poly_d;
    logic [VERI_BITS-1:0]    crc_q, crc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
    logic [VERI_BITS-1:0]    residue_q, residue_d;
    logic [VERI_BITS-1:0]    crc_step;

    crc_bit_step #(
        .VERI_BITS (VERI_BITS)
    ) u_step (
        .crc_cur (crc_q),
        .bit_in  (shift_q[TOTAL_BITS-1]),
        .poly    (poly_q),
        .crc_nxt (crc_step)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        poly_d    = poly_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        residue_d = residue_q;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d   = S_CALC;
                    shift_d   = {data, crc_in};
                    poly_d    = veri_poly;
                    crc_d     = '0;
                    cnt_d     = '0;
                    pass_d    = 1'b0;
                    residue_d = '0;
                end
            end
            S_CALC: begin
                // The edge after the last shift publishes the result.
                if (cnt_q == CNT_LAST) begin
                    state_d   = S_DONE;
                    residue_d = crc_q;
                    pass_d    = (crc_q == '0);
                    done_d    = 1'b1;
                end else begin
                    shift_d = {shift_q[TOTAL_BITS-2:0], 1'b0};
                    crc_d   = crc_step;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            poly_q    <= '0;
            crc_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            residue_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            poly_q    <= poly_d;
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            residue_q <= residue_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign pass    = pass_q;
    assign residue = residue_q;

endmodule

// File: tb/tb_crc_check.sv
// Directed bench for crc_check: an 8/8 instance for timing and corner cases,
// and a 32/32 instance for the default CRC-32 polynomial.
module tb_crc_check;

    logic clk;
    logic rst;

    logic        en8;
    logic [7:0]  poly8, data8, crc8, residue8;
    logic        busy8, done8, pass8;

    logic        en32;
    logic [31:0] poly32, data32, crc32, residue32;
    logic        busy32, done32, pass32;

    int n_vec;
    int n_bad;

    crc_check #(.VERI_BITS(8), .DATA_BITS(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .en        (en8),
        .veri_poly (poly8),
        .data      (data8),
        .crc_in    (crc8),
        .busy      (busy8),
        .done      (done8),
        .pass      (pass8),
        .residue   (residue8)
    );

    crc_check #(.VERI_BITS(32), .DATA_BITS(32)) dut32 (
        .clk       (clk),
        .rst       (rst),
        .en        (en32),
        .veri_poly (poly32),
        .data      (data32),
        .crc_in    (crc32),
        .busy      (busy32),
        .done      (done32),
        .pass      (pass32),
        .residue   (residue32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start one check on the 8/8 instance and follow it to its done pulse.
    task automatic run8(input string tag, input logic [7:0] d, input logic [7:0] c,
                        input logic [7:0] p, input logic exp_pass,
                        input logic [7:0] exp_res, input bit scramble);
        int lat;
        lat = -1;
        @(negedge clk);
        data8 = d; crc8 = c; poly8 = p; en8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en8 = 1'b0;
        chk_eq({tag, ".busy_after_start"}, 32'(busy8), 32'd1);
        if (scramble) begin
            data8 = 8'hFF; crc8 = 8'hFF; poly8 = 8'hFF;
        end
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done8) lat = k;
        end
        chk_eq({tag, ".latency"}, 32'(lat), 32'd17);
        if (lat >= 0) begin
            chk_eq({tag, ".pass"}, 32'(pass8), 32'(exp_pass));
            chk_eq({tag, ".residue"}, 32'(residue8), 32'(exp_res));
            @(posedge clk);
            @(negedge clk);
            chk_eq({tag, ".done_one_cycle"}, 32'(done8), 32'd0);
            chk_eq({tag, ".idle_after"}, 32'(busy8), 32'd0);
            chk_eq({tag, ".pass_held"}, 32'(pass8), 32'(exp_pass));
        end
    endtask

    task automatic run32(input string tag, input logic [31:0] d, input logic [31:0] c,
                         input logic exp_pass, input logic [31:0] exp_res);
        int lat;
        lat = -1;
        @(negedge clk);
        data32 = d; crc32 = c; poly32 = 32'h04C11DB7; en32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en32 = 1'b0;
        for (int k = 1; k <= 100 && lat < 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done32) lat = k;
        end
        chk_eq({tag, ".latency"}, 32'(lat), 32'd65);
        if (lat >= 0) begin
            chk_eq({tag, ".pass"}, 32'(pass32), 32'(exp_pass));
            chk_eq({tag, ".residue"}, residue32, exp_res);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int lowrun;
        int ndone;
        int last;
        int stale;
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        en8 = 1'b0; poly8 = 8'h00; data8 = 8'h00; crc8 = 8'h00;
        en32 = 1'b0; poly32 = 32'h0; data32 = 32'h0; crc32 = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("reset.busy", 32'(busy8), 32'd0);
        chk_eq("reset.done", 32'(done8), 32'd0);
        chk_eq("reset.pass", 32'(pass8), 32'd0);
        chk_eq("reset.residue", 32'(residue8), 32'd0);
        chk_eq("reset.busy32", 32'(busy32), 32'd0);
        rst = 1'b0;

        // x^8 mod (x^8+x^2+x+1) = 0x07, x^9 mod G = 0x0E.
        run8("t1_good", 8'h01, 8'h07, 8'h07, 1'b1, 8'h00, 1'b0);
        run8("t2_bad", 8'h01, 8'h06, 8'h07, 1'b0, 8'h07, 1'b0);
        run8("t2_good", 8'h02, 8'h0E, 8'h07, 1'b1, 8'h00, 1'b0);
        run8("t3_zero_captured", 8'h00, 8'h00, 8'h07, 1'b1, 8'h00, 1'b1);

        // Continuous en: a start every 16 calc + result + done + idle = 19 edges.
        @(negedge clk);
        data8 = 8'h01; crc8 = 8'h07; poly8 = 8'h07; en8 = 1'b1;
        lowrun = 0; ndone = 0; last = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (!busy8) begin
                lowrun++;
                chk_eq("t4.idle_run", 32'(lowrun), 32'd1);
            end else begin
                lowrun = 0;
            end
            if (done8) begin
                ndone++;
                chk_eq("t4.pass", 32'(pass8), 32'd1);
                if (last >= 0) chk_eq("t4.interval", 32'(k - last), 32'd19);
                last = k;
            end
        end
        en8 = 1'b0;
        chk_eq("t4.done_count", 32'(ndone), 32'd3);
        repeat (25) @(negedge clk);
        chk_eq("t4.drained", 32'(busy8), 32'd0);

        // Reset in the middle of a check.
        @(negedge clk);
        data8 = 8'h02; crc8 = 8'h0E; poly8 = 8'h07; en8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en8 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_eq("t5.busy", 32'(busy8), 32'd0);
        chk_eq("t5.done", 32'(done8), 32'd0);
        chk_eq("t5.pass", 32'(pass8), 32'd0);
        chk_eq("t5.residue", 32'(residue8), 32'd0);
        rst = 1'b0;
        stale = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done8 || busy8) stale++;
        end
        chk_eq("t5.no_stale_done", 32'(stale), 32'd0);
        run8("t5_restart", 8'h02, 8'h0E, 8'h07, 1'b1, 8'h00, 1'b0);

        // CRC-32 polynomial: x^32 mod G = 0x04C11DB7.
        run32("t6_good", 32'h00000001, 32'h04C11DB7, 1'b1, 32'h00000000);
        run32("t6_bad", 32'h00000001, 32'h04C11DB6, 1'b0, 32'h04C11DB7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
